// File: rtl/processor.sv
// rtl/processor.sv - multi-cycle 32-bit RISC core (FETCH/EXEC/MEM)
module processor (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB,
  output logic        wren,
  output logic [31:0] address_dmem,
  output logic [31:0] data,
  input  logic [31:0] q_dmem
);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

  state_t      state, next_state;
  logic [31:0] pc, pc_next;
  logic [4:0]  lw_rd;
  logic [31:0] lw_addr;

  logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
  logic [31:0] imm_ext, t_ext;
  logic [31:0] sum_rr, diff_rr, sum_ri, pc_plus1, branch_target;
  logic        ovf_add, ovf_sub, ovf_addi;
  logic        write_req;

  assign opcode  = q_imem[31:27];
  assign rd      = q_imem[26:22];
  assign rs      = q_imem[21:17];
  assign rt      = q_imem[16:12];
  assign shamt   = q_imem[11:7];
  assign aluop   = q_imem[6:2];
  assign imm_ext = {{15{q_imem[16]}}, q_imem[16:0]};
  assign t_ext   = {5'b0, q_imem[26:0]};

  assign sum_rr        = data_readRegA + data_readRegB;
  assign diff_rr       = data_readRegA - data_readRegB;
  assign sum_ri        = data_readRegA + imm_ext;
  assign pc_plus1      = pc + 32'd1;
  assign branch_target = pc_plus1 + imm_ext;

  assign ovf_add  = (data_readRegA[31] == data_readRegB[31]) && (sum_rr[31] != data_readRegA[31]);
  assign ovf_sub  = (data_readRegA[31] != data_readRegB[31]) && (diff_rr[31] != data_readRegA[31]);
  assign ovf_addi = (data_readRegA[31] == imm_ext[31]) && (sum_ri[31] != data_readRegA[31]);

  // r0 is hard-wired, so a write request aimed at it is simply dropped
  assign ctrl_writeEnable = write_req && (ctrl_writeReg != 5'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      pc      <= 32'd0;
      lw_rd   <= 5'd0;
      lw_addr <= 32'd0;
    end else begin
      state <= next_state;
      pc    <= pc_next;
      if (state == EXEC && opcode == OP_LW) begin
        lw_rd   <= rd;
        lw_addr <= sum_ri;
      end
    end
  end

  always_comb begin
    next_state    = state;
    pc_next       = pc;
    address_imem  = pc;
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;
    write_req     = 1'b0;
    ctrl_writeReg = 5'd0;
    data_writeReg = 32'd0;
    wren          = 1'b0;
    address_dmem  = 32'd0;
    data          = 32'd0;
    case (state)
      FETCH: next_state = EXEC;
      EXEC: begin
        next_state = FETCH;
        pc_next    = pc_plus1;
        case (opcode)
          OP_R: begin
            ctrl_readRegA = rs;
            ctrl_readRegB = rt;
            ctrl_writeReg = rd;
            case (aluop)
              5'b00000: begin
                write_req = 1'b1;
                if (ovf_add) begin
                  ctrl_writeReg = 5'd30;
                  data_writeReg = 32'd1;
                end else begin
                  data_writeReg = sum_rr;
                end
              end
              5'b00001: begin
                write_req = 1'b1;
                if (ovf_sub) begin
                  ctrl_writeReg = 5'd30;
                  data_writeReg = 32'd3;
                end else begin
                  data_writeReg = diff_rr;
                end
              end
              5'b00010: begin
                write_req     = 1'b1;
                data_writeReg = data_readRegA & data_readRegB;
              end
              5'b00011: begin
                write_req     = 1'b1;
                data_writeReg = data_readRegA | data_readRegB;
              end
              5'b00100: begin
                write_req     = 1'b1;
                data_writeReg = data_readRegA << shamt;
              end
              5'b00101: begin
                write_req     = 1'b1;
                data_writeReg = $unsigned($signed(data_readRegA) >>> shamt);
              end
              default: write_req = 1'b0;
            endcase
          end
          OP_ADDI: begin
            ctrl_readRegA = rs;
            write_req     = 1'b1;
            if (ovf_addi) begin
              ctrl_writeReg = 5'd30;
              data_writeReg = 32'd2;
            end else begin
              ctrl_writeReg = rd;
              data_writeReg = sum_ri;
            end
          end
          OP_SW: begin
            ctrl_readRegA = rs;
            ctrl_readRegB = rd;
            wren          = 1'b1;
            address_dmem  = sum_ri;
            data          = data_readRegB;
          end
          OP_LW: begin
            ctrl_readRegA = rs;
            address_dmem  = sum_ri;
            next_state    = MEM;
            pc_next       = pc;
          end
          OP_J: pc_next = t_ext;
          OP_BNE: begin
            ctrl_readRegA = rs;
            ctrl_readRegB = rd;
            if (data_readRegB != data_readRegA) pc_next = branch_target;
          end
          OP_BLT: begin
            ctrl_readRegA = rs;
            ctrl_readRegB = rd;
            if ($signed(data_readRegB) < $signed(data_readRegA)) pc_next = branch_target;
          end
          OP_JAL: begin
            write_req     = 1'b1;
            ctrl_writeReg = 5'd31;
            data_writeReg = pc_plus1;
            pc_next       = t_ext;
          end
          OP_JR: begin
            ctrl_readRegB = rd;
            pc_next       = data_readRegB;
          end
          OP_BEX: begin
            ctrl_readRegB = 5'd30;
            if (data_readRegB != 32'd0) pc_next = t_ext;
          end
          OP_SETX: begin
            write_req     = 1'b1;
            ctrl_writeReg = 5'd30;
            data_writeReg = t_ext;
          end
          default: pc_next = pc_plus1;
        endcase
      end
      MEM: begin
        // ROM output is still stable here, but the latched copies are authoritative
        address_dmem  = lw_addr;
        write_req     = 1'b1;
        ctrl_writeReg = lw_rd;
        data_writeReg = q_dmem;
        next_state    = FETCH;
        pc_next       = pc_plus1;
      end
      default: next_state = FETCH;
    endcase
  end

endmodule

// File: tb/tb_processor.sv
// tb/tb_processor.sv - directed self-checking bench for processor with ROM/RAM/regfile models
module tb_processor;

  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] address_imem, q_imem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;
  logic        wren;
  logic [31:0] address_dmem, data, q_dmem;

  logic [31:0] rom [0:4095];
  logic [31:0] ram [0:4095];
  logic [31:0] rf  [0:31];
  int          wren_cnt;
  int          r0_writes;
  int          total = 0;
  int          bad = 0;

  processor dut (
    .clock(clock), .reset(reset),
    .address_imem(address_imem), .q_imem(q_imem),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_writeReg(data_writeReg), .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .wren(wren), .address_dmem(address_dmem), .data(data), .q_dmem(q_dmem)
  );

  always #5 clock = ~clock;

  assign data_readRegA = rf[ctrl_readRegA];
  assign data_readRegB = rf[ctrl_readRegB];

  always @(posedge clock) begin
    q_imem <= rom[address_imem[11:0]];
    q_dmem <= ram[address_dmem[11:0]];
    if (clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      for (int i = 0; i < 4096; i++) ram[i] <= 32'd0;
      wren_cnt  <= 0;
      r0_writes <= 0;
    end else begin
      if (wren) begin
        ram[address_dmem[11:0]] <= data;
        wren_cnt <= wren_cnt + 1;
      end
      if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
      if (ctrl_writeEnable && ctrl_writeReg == 5'd0) r0_writes <= r0_writes + 1;
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs, rt, shamt, aluop);
    return {5'b00000, rd, rs, rt, shamt, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] t);
    return {op, t};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 32'd0;
  endtask

  task automatic start_program();
    reset = 1'b0;
    clr   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    clr   = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic load_mem_program();
    clear_rom();
    rom[0] = enc_i(OP_ADDI, 5'd4, 5'd0, 17'd42);
    rom[1] = enc_i(OP_SW,   5'd4, 5'd0, 17'd3);
    rom[2] = enc_i(OP_LW,   5'd5, 5'd0, 17'd3);
    rom[3] = enc_i(OP_ADDI, 5'd6, 5'd5, 17'd1);
    rom[4] = enc_j(OP_J, 27'd4);
  endtask

  task automatic test_arith();
    logic [4:0]  idx [0:9];
    logic [31:0] exp_v [0:9];
    clear_rom();
    rom[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 17'd5);
    rom[1] = enc_i(OP_ADDI, 5'd2, 5'd0, 17'd7);
    rom[2] = enc_r(5'd3, 5'd1, 5'd2, 5'd0, 5'd0);
    rom[3] = enc_r(5'd4, 5'd2, 5'd1, 5'd0, 5'd1);
    rom[4] = enc_r(5'd5, 5'd1, 5'd2, 5'd0, 5'd2);
    rom[5] = enc_r(5'd6, 5'd1, 5'd2, 5'd0, 5'd3);
    rom[6] = enc_i(OP_ADDI, 5'd7, 5'd0, 17'h1FFF8);
    rom[7] = enc_r(5'd8, 5'd7, 5'd0, 5'd2, 5'd5);
    rom[8] = enc_r(5'd9, 5'd1, 5'd2, 5'd0, 5'd8);
    rom[9] = enc_j(OP_J, 27'd9);
    start_program();
    step(1);
    total++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd1, 32'd5}) begin
      bad++;
      $display("FAIL arith_exec_write got=%b/%0d/%0h exp=1/1/5", ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    total++;
    if (rf[1] !== 32'd0) begin bad++; $display("FAIL arith_r1_early got=%0h exp=0", rf[1]); end
    step(1);
    total++;
    if (rf[1] !== 32'd5) begin bad++; $display("FAIL arith_r1_second_cycle got=%0h exp=5", rf[1]); end
    step(20);
    idx   = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd30};
    exp_v = '{32'd5, 32'd7, 32'd12, 32'd2, 32'd5, 32'd7, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'd0, 32'd0};
    for (int i = 0; i < 10; i++) begin
      total++;
      if (rf[idx[i]] !== exp_v[i]) begin
        bad++;
        $display("FAIL arith_r%0d got=%0h exp=%0h", idx[i], rf[idx[i]], exp_v[i]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({address_imem, wren, ctrl_writeEnable, address_dmem, data} !== {32'd0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset_outputs got=imem %0h wren %b we %b dmem %0h data %0h exp=all zero",
               address_imem, wren, ctrl_writeEnable, address_dmem, data);
    end
    step(2);
    total++;
    if (address_imem !== 32'd0) begin bad++; $display("FAIL reset_hold_pc got=%0h exp=0", address_imem); end
  endtask

  task automatic test_overflow();
    logic [4:0]  idx [0:4];
    logic [31:0] exp_v [0:4];
    clear_rom();
    rom[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 17'h0FFFF);
    rom[1] = enc_r(5'd1, 5'd1, 5'd0, 5'd15, 5'd4);
    rom[2] = enc_i(OP_ADDI, 5'd1, 5'd1, 17'h07FFF);
    rom[3] = enc_r(5'd2, 5'd1, 5'd1, 5'd0, 5'd0);
    rom[4] = enc_i(OP_ADDI, 5'd5, 5'd0, 17'd1);
    rom[5] = enc_r(5'd6, 5'd5, 5'd0, 5'd31, 5'd4);
    rom[6] = enc_r(5'd7, 5'd6, 5'd5, 5'd0, 5'd1);
    rom[7] = enc_i(OP_ADDI, 5'd8, 5'd1, 17'd1);
    rom[8] = enc_j(OP_J, 27'd8);
    start_program();
    step(7);
    total++;
    if ({ctrl_writeReg, data_writeReg} !== {5'd30, 32'd1}) begin
      bad++;
      $display("FAIL ovf_add_redirect got=r%0d val %0h exp=r30 val 1", ctrl_writeReg, data_writeReg);
    end
    step(1);
    total++;
    if (rf[30] !== 32'd1) begin bad++; $display("FAIL ovf_add_r30 got=%0h exp=1", rf[30]); end
    step(6);
    total++;
    if (rf[30] !== 32'd3) begin bad++; $display("FAIL ovf_sub_r30 got=%0h exp=3", rf[30]); end
    step(2);
    total++;
    if (rf[30] !== 32'd2) begin bad++; $display("FAIL ovf_addi_r30 got=%0h exp=2", rf[30]); end
    step(4);
    idx   = '{5'd1, 5'd2, 5'd6, 5'd7, 5'd8};
    exp_v = '{32'h7FFFFFFF, 32'd0, 32'h80000000, 32'd0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rf[idx[i]] !== exp_v[i]) begin
        bad++;
        $display("FAIL ovf_r%0d got=%0h exp=%0h", idx[i], rf[idx[i]], exp_v[i]);
      end
    end
  endtask

  task automatic test_mem();
    load_mem_program();
    start_program();
    step(3);
    total++;
    if ({wren, address_dmem, data, ctrl_writeEnable} !== {1'b1, 32'd3, 32'd42, 1'b0}) begin
      bad++;
      $display("FAIL sw_exec got=wren %b addr %0h data %0h we %b exp=1/3/42/0", wren, address_dmem, data, ctrl_writeEnable);
    end
    step(2);
    total++;
    if ({wren, ctrl_writeEnable, address_dmem} !== {1'b0, 1'b0, 32'd3}) begin
      bad++;
      $display("FAIL lw_exec got=wren %b we %b addr %0h exp=0/0/3", wren, ctrl_writeEnable, address_dmem);
    end
    step(1);
    total++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, address_dmem, address_imem} !==
        {1'b1, 5'd5, 32'd42, 32'd3, 32'd2}) begin
      bad++;
      $display("FAIL lw_mem got=we %b r%0d val %0h addr %0h pc %0h exp=1/r5/42/3/2",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg, address_dmem, address_imem);
    end
    step(1);
    total++;
    if (rf[5] !== 32'd42) begin bad++; $display("FAIL lw_r5 got=%0h exp=42", rf[5]); end
    step(10);
    total++;
    if ({wren_cnt, rf[6], ram[3]} !== {32'sd1, 32'd43, 32'd42}) begin
      bad++;
      $display("FAIL mem_final got=wren_cycles %0d r6 %0h ram3 %0h exp=1/43/42", wren_cnt, rf[6], ram[3]);
    end
  endtask

  task automatic test_branch();
    logic [31:0] seq [0:7];
    clear_rom();
    rom[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 17'd1);
    rom[1] = enc_i(OP_ADDI, 5'd2, 5'd0, 17'd2);
    rom[2] = enc_i(OP_BNE,  5'd1, 5'd2, 17'd2);
    rom[3] = enc_i(OP_ADDI, 5'd10, 5'd0, 17'd1);
    rom[4] = enc_i(OP_ADDI, 5'd11, 5'd0, 17'd1);
    rom[5] = enc_i(OP_BLT,  5'd2, 5'd1, 17'd3);
    rom[6] = enc_i(OP_ADDI, 5'd12, 5'd0, 17'd9);
    rom[7] = enc_i(OP_BLT,  5'd1, 5'd2, 17'd1);
    rom[8] = enc_i(OP_ADDI, 5'd13, 5'd0, 17'd1);
    rom[9] = enc_j(OP_J, 27'd9);
    seq = '{32'd0, 32'd1, 32'd2, 32'd5, 32'd6, 32'd7, 32'd9, 32'd9};
    start_program();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (address_imem !== seq[i]) begin
        bad++;
        $display("FAIL branch_fetch%0d got=%0h exp=%0h", i, address_imem, seq[i]);
      end
      step(2);
    end
    total++;
    if ({rf[10], rf[11], rf[12], rf[13]} !== {32'd0, 32'd0, 32'd9, 32'd0}) begin
      bad++;
      $display("FAIL branch_regs got=%0h %0h %0h %0h exp=0 0 9 0", rf[10], rf[11], rf[12], rf[13]);
    end
  endtask

  task automatic test_jump();
    logic [31:0] seq [0:8];
    clear_rom();
    rom[0]  = enc_j(OP_BEX, 27'd25);
    rom[1]  = enc_j(OP_JAL, 27'd10);
    rom[2]  = enc_j(OP_SETX, 27'd5);
    rom[3]  = enc_j(OP_BEX, 27'd20);
    rom[10] = enc_i(OP_ADDI, 5'd3, 5'd0, 17'd7);
    rom[11] = enc_i(OP_JR, 5'd31, 5'd0, 17'd0);
    rom[20] = enc_i(OP_ADDI, 5'd4, 5'd0, 17'd9);
    rom[21] = enc_j(OP_J, 27'd21);
    seq = '{32'd0, 32'd1, 32'd10, 32'd11, 32'd2, 32'd3, 32'd20, 32'd21, 32'd21};
    start_program();
    for (int i = 0; i < 9; i++) begin
      total++;
      if (address_imem !== seq[i]) begin
        bad++;
        $display("FAIL jump_fetch%0d got=%0h exp=%0h", i, address_imem, seq[i]);
      end
      step(2);
    end
    total++;
    if ({rf[31], rf[30], rf[3], rf[4]} !== {32'd2, 32'd5, 32'd7, 32'd9}) begin
      bad++;
      $display("FAIL jump_regs got=r31 %0h r30 %0h r3 %0h r4 %0h exp=2 5 7 9", rf[31], rf[30], rf[3], rf[4]);
    end
  endtask

  task automatic test_reset_mid();
    load_mem_program();
    start_program();
    step(3);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({wren, ctrl_writeEnable, address_imem} !== {1'b0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL midreset_outputs got=wren %b we %b pc %0h exp=0/0/0", wren, ctrl_writeEnable, address_imem);
    end
    step(2);
    total++;
    if ({ram[3], wren_cnt} !== {32'd0, 32'sd0}) begin
      bad++;
      $display("FAIL midreset_no_store got=ram3 %0h wren_cycles %0d exp=0/0", ram[3], wren_cnt);
    end
    reset = 1'b1;
    step(16);
    total++;
    if ({rf[4], rf[5], rf[6], ram[3]} !== {32'd42, 32'd42, 32'd43, 32'd42}) begin
      bad++;
      $display("FAIL midreset_rerun got=r4 %0h r5 %0h r6 %0h ram3 %0h exp=42 42 43 42", rf[4], rf[5], rf[6], ram[3]);
    end
    total++;
    if (r0_writes !== 0) begin bad++; $display("FAIL r0_write_strobe got=%0d exp=0", r0_writes); end
  endtask

  initial begin
    clear_rom();
    test_arith();
    test_reset();
    test_overflow();
    test_mem();
    test_branch();
    test_jump();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/processor.md
# processor

Multi-cycle 32-bit RISC core that fetches from an external synchronous instruction ROM, reads and writes an external 32-register register file, and loads and stores through an external synchronous data RAM. It sits at the centre of the top-level wrapper, which owns the ROM (12-bit word address), the RAM (12-bit word address) and the regfile. The core holds only PC, FSM state and a small amount of pipeline state.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; clears PC and FSM.
- address_imem  out  32  word address of the instruction; the wrapper uses bits [11:0].
- q_imem  in  32  ROM data, registered by the ROM one rising edge after the address is presented.
- ctrl_writeEnable  out  1  regfile write strobe; the write happens on the rising edge.
- ctrl_writeReg  out  5  destination register.
- ctrl_readRegA, ctrl_readRegB  out  5 each  regfile read addresses; reads are combinational.
- data_writeReg  out  32  write data.
- data_readRegA, data_readRegB  in  32 each  regfile read data.
- wren  out  1  RAM write enable.
- address_dmem  out  32  RAM word address.
- data  out  32  RAM write data.
- q_dmem  in  32  RAM read data, registered one rising edge after the address.

## Operation
- Instruction fields:
  - opcode [31:27]; rd [26:22]; rs [21:17]; rt [16:12]; shamt [11:7]; aluop [6:2].
  - imm [16:0], sign-extended to 32 bits.
  - T [26:0], zero-extended.
- R-type (opcode 00000): rd = rs op rt.
  - aluop 00000 add, 00001 sub, 00010 and, 00011 or.
  - aluop 00100 sll by shamt, 00101 sra by shamt (both shift rs).
  - Any other aluop is a nop.
- Overflow: signed overflow on add, addi or sub writes r30 instead of rd, with value 1 (add), 2 (addi) or 3 (sub).
- Other opcodes:
  - addi 00101: rd = rs + imm.
  - sw 00111: mem[rs + imm] = rd.
  - lw 01000: rd = mem[rs + imm].
  - j 00001: PC = T.
  - bne 00010: if rd != rs, PC = PC + 1 + imm.
  - jal 00011: r31 = PC + 1; PC = T.
  - jr 00100: PC = rd.
  - blt 00110: if rd < rs (signed), PC = PC + 1 + imm.
  - bex 10110: if r30 != 0, PC = T.
  - setx 10101: r30 = T.
  - All other opcodes are nops (PC + 1).
- Read-port mapping:
  - R-type: A = rs, B = rt.
  - addi and lw: A = rs.
  - sw: A = rs, B = rd.
  - bne and blt: A = rs, B = rd.
  - jr: B = rd.
  - bex: B = 30.
- ctrl_writeEnable is never asserted with ctrl_writeReg = 0.
- Arithmetic is 32-bit two's complement and wraps. Branch and jump targets are truncated to 32 bits. PC increments by 1 per word.

## Timing
- FSM states: FETCH, EXEC, MEM.
  - FETCH drives address_imem = PC; the next state is EXEC.
  - EXEC: q_imem is valid and address_imem is held at PC, so the ROM output stays stable. Decode, register read, ALU and branch evaluation are all combinational in this cycle.
    - Non-lw in EXEC: the regfile write and the sw RAM write (wren = 1, address_dmem = rs + imm, data = rd value) commit on the closing edge. PC takes its next value and the state returns to FETCH.
    - lw in EXEC: drives address_dmem; the next state is MEM.
  - MEM holds address_dmem and asserts ctrl_writeEnable with data_writeReg = q_dmem. PC advances to PC + 1 and the state returns to FETCH.
- Latency: 2 cycles per instruction, 3 for lw.
- Outside an active write: wren = 0, ctrl_writeEnable = 0, data = 0, address_dmem = 0.
- The write value and destination are latched in EXEC and must be stable in MEM.
- Reset (low, any time, including mid-instruction):
  - Immediately: PC = 0, state = FETCH, wren = 0, ctrl_writeEnable = 0, address_imem = 0.
  - Any in-flight write is cancelled.
  - On release, fetch starts from address 0 on the next rising edge.
- Branch offset base is the address of the branch itself + 1.

## Test plan
- Reset then addi r1, r0, 5; addi r2, r0, 7; add r3, r1, r2 -> r1 = 5, r2 = 7, r3 = 12. Each regfile write lands in the second cycle of its instruction.
- addi r1, r0, 0x7FFF, shifted up to 0x7FFFFFFF, then add r2, r1, r1 -> r2 unchanged; r30 = 1. sub of 0x80000000 − 1 -> r30 = 3.
- sw r4, 3(r0) with r4 = 42, then lw r5, 3(r0) -> wren high for exactly one cycle at address 3. r5 = 42, written in the third lw cycle.
- bne taken (r1 = 1, r2 = 2, imm = 2) skips 2 instructions; blt not taken when rd ≥ rs. The PC sequence on address_imem matches.
- jal 10 -> r31 = PC + 1 and the next fetch is from 10. jr r31 returns. setx 5 then bex 20 -> fetch from 20.
- Assert reset low mid-EXEC of an sw -> no RAM write, PC = 0, and the re-run program produces identical final register values.
